// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin decoded arbiter: requester count, FSM encoding and the
// rotating-priority pick function.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // First set bit scanning ptr, ptr+1, ... modulo 4; the downward loop lets the lowest offset win.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/arb_dec2to4.sv
// Gate-level 2-to-4 decoder with enable; a is the select MSB, b the LSB.
module arb_dec2to4 (
  input  logic a,
  input  logic b,
  input  logic e,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3
);

  logic na;
  logic nb;

  not u_na (na, a);
  not u_nb (nb, b);

  and u_d0 (d0, e, na, nb);
  and u_d1 (d1, e, na, b);
  and u_d2 (d2, e, a, nb);
  and u_d3 (d3, e, a, b);

endmodule

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter driving a 2-to-4 enable decoder. Holds a grant until release or hold
// timeout, and always inserts one enable-low cycle between grants.
module rr_dec_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [1:0]         sel,
  output logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               expire
);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= 2'd0;
      ptr_q    <= 2'd0;
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          sel_d   = rr_pick(req, ptr_q);
          cnt_d   = CNT_W'(1);
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[sel_q]) begin
          state_d = ST_IDLE;
          ptr_d   = sel_q + 2'd1;
        end else if (MAX_HOLD != 0 && cnt_q == CNT_W'(MAX_HOLD)) begin
          state_d  = ST_IDLE;
          ptr_d    = sel_q + 2'd1;
          expire_d = 1'b1;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en     = (state_q == ST_GRANT);
    busy   = en;
    sel    = sel_q;
    expire = expire_q;
  end

  arb_dec2to4 u_dec (
    .a  (sel_q[1]),
    .b  (sel_q[0]),
    .e  (en),
    .d0 (gnt[0]),
    .d1 (gnt[1]),
    .d2 (gnt[2]),
    .d3 (gnt[3])
  );

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Randomised bench for rr_dec_arbiter: a timeout build and a no-timeout build share one request
// stream, each checked cycle by cycle against an owner/priority model.
module tb_rr_dec_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;

  logic [1:0] sel0, sel1;
  logic       en0, en1, busy0, busy1, exp0, exp1;
  logic [3:0] gnt0, gnt1;

  int n_vec = 0;
  int n_err = 0;

  // Model state per instance: 0 = MAX_HOLD 16, 1 = MAX_HOLD 0.
  int   owner[2];
  int   held[2];
  int   nxt[2];
  int   last[2];
  bit   m_exp[2];
  logic [3:0] prev_gnt[2];
  int   hold_lim[2] = '{16, 0};

  always #5 clk = ~clk;

  rr_dec_arbiter #(.MAX_HOLD(16), .CNT_W(5)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .req (req), .sel (sel0), .en (en0),
    .gnt (gnt0), .busy (busy0), .expire (exp0)
  );

  rr_dec_arbiter #(.MAX_HOLD(0), .CNT_W(5)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .req (req), .sel (sel1), .en (en1),
    .gnt (gnt1), .busy (busy1), .expire (exp1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = -1; held[i] = 0; nxt[i] = 0; last[i] = 0; m_exp[i] = 1'b0;
      prev_gnt[i] = 4'b0000;
    end
  endtask

  task automatic model_step(input int i, input logic [3:0] r);
    m_exp[i] = 1'b0;
    if (owner[i] < 0) begin
      for (int k = 3; k >= 0; k--)
        if (r[(nxt[i] + k) % 4]) owner[i] = (nxt[i] + k) % 4;
      if (owner[i] >= 0) begin
        held[i] = 1;
        last[i] = owner[i];
      end
    end else if (!r[owner[i]]) begin
      nxt[i] = (owner[i] + 1) % 4;
      owner[i] = -1;
    end else if (hold_lim[i] != 0 && held[i] == hold_lim[i]) begin
      nxt[i] = (owner[i] + 1) % 4;
      owner[i] = -1;
      m_exp[i] = 1'b1;
    end else begin
      held[i]++;
    end
  endtask

  task automatic check_inst(input int i, input logic [3:0] g, input logic [1:0] s, input logic e,
                            input logic b, input logic x);
    logic [3:0] want_g;
    want_g = (owner[i] >= 0) ? (4'b0001 << owner[i]) : 4'b0000;
    check($sformatf("gnt%0d", i), 32'(g), 32'(want_g));
    check($sformatf("en%0d", i), 32'(e), 32'(owner[i] >= 0));
    check($sformatf("busy%0d", i), 32'(b), 32'(owner[i] >= 0));
    check($sformatf("expire%0d", i), 32'(x), 32'(m_exp[i]));
    check($sformatf("sel%0d", i), 32'(s), 32'(last[i]));
    check($sformatf("onehot%0d", i), 32'($onehot0(g)), 32'd1);
    check($sformatf("gnt_off%0d", i), 32'(!e && g != 4'b0000), 32'd0);
    check($sformatf("guard%0d", i),
          32'(prev_gnt[i] != 4'b0000 && g != 4'b0000 && prev_gnt[i] != g), 32'd0);
    prev_gnt[i] = g;
  endtask

  task automatic check_all();
    check_inst(0, gnt0, sel0, en0, busy0, exp0);
    check_inst(1, gnt1, sel1, en1, busy1, exp1);
  endtask

  task automatic tick(input logic [3:0] r);
    req = r;
    @(posedge clk);
    if (rst_n) begin
      model_step(0, r);
      model_step(1, r);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Single requester grant and release.
    tick(4'b0001);
    check("t1_gnt", 32'(gnt0), 32'h1);
    tick(4'b0000);
    check("t1_release", 32'(gnt0), 32'h0);

    // All requesting: timeout rotation in dut0, sticky owner in dut1.
    do_reset();
    repeat (80) tick(4'b1111);

    // Early release hands over after one idle cycle.
    do_reset();
    repeat (3) tick(4'b0101);
    tick(4'b0100);
    check("t3_idle", 32'(gnt0), 32'h0);
    tick(4'b0100);
    check("t3_next", 32'(gnt0), 32'h4);

    // Pointer after granting 1 favours 3, then wraps to 0.
    do_reset();
    tick(4'b0010);
    tick(4'b0000);
    tick(4'b1011);
    check("t4_win3", 32'(gnt0), 32'h8);
    tick(4'b0011);
    tick(4'b0011);
    check("t4_win0", 32'(gnt0), 32'h1);

    // Asynchronous reset between edges kills the grant immediately.
    do_reset();
    tick(4'b0100);
    #1 rst_n = 1'b0;
    #1;
    check("t5_gnt_async", 32'(gnt0), 32'h0);
    check("t5_en_async", 32'(en0), 32'h0);
    model_reset();
    #1 rst_n = 1'b1;
    tick(4'b0010);
    check("t5_regrant", 32'(gnt0), 32'h2);

    // No-timeout build keeps one owner indefinitely.
    do_reset();
    repeat (100) begin
      tick(4'b0100);
      check("t6_hold", 32'(gnt1), 32'h4);
    end

    // Random request traffic.
    do_reset();
    r = 4'b0000;
    repeat (3000) begin
      if ($urandom_range(0, 4) == 0) r = 4'($urandom_range(0, 15));
      tick(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
